// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM
// state encoding and the baud divider derivation used by TX (and later RX).
package uart_tx_cfg_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clock cycles per serial bit.
  function automatic int baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Width of a counter that runs 0 .. cnt_max-1 (cnt_max >= 2).
  function automatic int baud_cnt_width(input int cnt_max);
    return (cnt_max <= 2) ? 1 : $clog2(cnt_max);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_baud_gen.sv
// Bit-period timer: counts 0..BAUD_CNT_MAX-1 while enabled and flags the
// last cycle of each bit period with a one-cycle tick.
module uart_tx_cfg_baud_gen
  import uart_tx_cfg_pkg::*;
#(
  parameter int BAUD_CNT_MAX = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = baud_cnt_width(BAUD_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Clear wins over counting so a newly accepted frame always starts a full bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Tick marks the final cycle of the current bit, independent of clear, so a
  // back-to-back accept still sees the end of the previous stop bit.
  assign tick = enable && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits LSB first, optional
// odd/even parity, 1 or 2 stop bits, valid/ready byte interface that allows
// frames to run back to back. The serial output is registered, so the line
// trails the FSM state by one clock.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  // Illegal configurations are rejected while elaborating.
  generate
    if (BAUD_CNT_MAX < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_t state_reg, state_next;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic        par_reg;
  logic        txd_reg;
  logic        txd_next;
  logic        baud_tick;
  logic        accept;
  logic [7:0]  data_masked;
  logic        par_calc;

  assign accept      = tx_valid && tx_ready;
  assign data_masked = tx_data & DATA_MASK;
  // Odd parity inverts the XOR so data plus parity carries an odd count of ones.
  assign par_calc    = (PARITY == UART_PAR_ODD) ? ~(^data_masked) : (^data_masked);

  uart_tx_cfg_baud_gen #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .enable(state_reg != ST_IDLE),
    .tick  (baud_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the stop state can loop straight back to START.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tx_valid) state_next = ST_START;
      end
      ST_START: begin
        if (baud_tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tick && bit_cnt_reg == DATA_LAST) begin
          state_next = (PARITY != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (baud_tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (baud_tick && bit_cnt_reg == STOP_LAST) begin
          state_next = tx_valid ? ST_START : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: line level for the next cycle plus handshake/status flags.
  always_comb begin
    txd_next = 1'b1;
    tx_ready = 1'b0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        tx_ready = 1'b1;
      end
      ST_START: begin
        txd_next = 1'b0;
        tx_busy  = 1'b1;
      end
      ST_DATA: begin
        txd_next = shift_reg[0];
        tx_busy  = 1'b1;
      end
      ST_PARITY: begin
        txd_next = par_reg;
        tx_busy  = 1'b1;
      end
      ST_STOP: begin
        tx_busy = 1'b1;
        if (baud_tick && bit_cnt_reg == STOP_LAST) begin
          tx_ready = 1'b1;
          tx_done  = 1'b1;
        end
      end
      default: begin
        txd_next = 1'b1;
      end
    endcase
  end

  // Datapath: latch byte and parity on accept, shift out on each data-bit wrap,
  // and count bits within DATA / STOP, restarting on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      par_reg     <= 1'b0;
    end else begin
      if (accept) begin
        shift_reg <= data_masked;
        par_reg   <= par_calc;
      end else if (state_reg == ST_DATA && baud_tick) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
      if (state_next != state_reg) begin
        bit_cnt_reg <= '0;
      end else if (baud_tick) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // Registered line driver; reset forces the idle (mark) level immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_reg <= 1'b1;
    end else begin
      txd_reg <= txd_next;
    end
  end

  assign uart_txd = txd_reg;

endmodule
